uart_tx_engine: RTL and testbench
=================================

# uart_tx_engine

Transmit engine of the UART TX path. Captures a byte on a load strobe, builds a 10-bit serial frame (start bit, data bits 0–6, bit nine, bit ten) and shifts it out LSB-first on `tx`, one bit per programmable baud interval. Bits nine and ten come from the existing `bit_9_10_decoder`, which resolves the data width and parity mode. `tx_rdy` tells the upstream CPU/interface logic when a new byte may be loaded.

## Interface
- `BAUD_W`, default 20: width of the baud interval count.
- `clk`  in  1: single system clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `load`  in  1: single-cycle strobe requesting transmission of `out_port`.
- `out_port`  in  8: byte to transmit.
- `eight`  in  1: 1 = 8 data bits, 0 = 7 data bits.
- `pen`  in  1: parity enable.
- `ohel`  in  1: 1 = odd parity, 0 = even parity. Used only when `pen`=1.
- `baud_k`  in  BAUD_W: bit time in `clk` cycles.
- `tx`  out  1: serial line. Idles high.
- `tx_rdy`  out  1: 1 = idle, a `load` is accepted.

## Operation
- **Reset** (`rst_n`=0, takes effect immediately):
  - `tx`=1, `tx_rdy`=1.
  - Shift register is all ones; `ldata`=0.
  - Baud counter=0, bit counter=0, `doit`=0.
- **States:** IDLE → CAPTURE → SEND → IDLE.
- **IDLE** (`tx_rdy`=1):
  - `load`=1 latches `out_port` into `ldata`, clears `tx_rdy` and moves to CAPTURE.
  - `load` is ignored in every other state. There is no queuing.
- **CAPTURE** (one cycle):
  - The shift register loads {`bit_ten`, `bit_nine`, `ldata[6:0]`, 1'b0}, using the decoder outputs for the current `eight`/`pen`/`ohel`/`ldata`.
  - `baud_k` is latched into a local copy. Values below 2 are clamped to 2.
  - Both counters clear, `doit`=1, and the state moves to SEND.
- **SEND:**
  - The baud counter counts 0..k−1. At k−1 it raises a one-cycle `btu`, wraps to 0, and increments the bit counter.
  - On `btu` the shift register shifts right with 1 shifted in.
  - `tx` is always `sr[0]`.
  - On the `btu` that makes the bit count reach 10: `doit`=0, `tx_rdy`=1, counters clear, shift register returns to all ones, state returns to IDLE.
- **Frame contents** (fixed by the decoder, 7N1 emits 1,1 for bits nine and ten):
  - 8N1: bit nine = d7, bit ten = 1.
  - 8-bit + parity: bit nine = d7, bit ten = parity over d0..d7.
  - 7-bit + parity: bit nine = parity over d0..d6, bit ten = 1.
  - Even parity = XOR reduction; odd parity = its complement.
- **Sampling:**
  - `eight`/`pen`/`ohel` matter only in the CAPTURE cycle.
  - `baud_k` is sampled only in CAPTURE. Changing it mid-frame has no effect on the current frame.

## Timing
- Cycle numbering:
  - `load` sampled at edge N.
  - `tx_rdy`=0 and `ldata` valid after edge N+1.
  - Start bit (`tx`=0) driven after edge N+2.
- Each of the 10 bits lasts exactly k cycles.
- `tx_rdy` rises after edge N+2+10k. `tx` is 1 from then on: the bit-ten slot when bit ten is 1, or idle.
- **Back-to-back:** a `load` in the first `tx_rdy`=1 cycle is accepted. The next start bit follows 2 cycles of idle-high `tx`.
- **`load` with `rst_n` low:** ignored.
- **Reset mid-frame:** `tx` returns high asynchronously and the frame is aborted. Operation resumes from IDLE on the first edge after `rst_n` deasserts.

## Structure
- Shared package `uart_pkg`:
  - `FRAME_BITS` = 10.
  - `BAUD_MIN` = 2.
  - `BAUD_W` default = 20.
  - State encoding IDLE/CAPTURE/SEND.
- Sub-module: one instance of `bit_9_10_decoder`, fed by `ldata`, `eight`, `pen`, `ohel`.
- Baud counter, bit counter, shift register and control FSM stay inline in `uart_tx_engine`.

## Test plan
- **8N1, `out_port`=0x55, `baud_k`=4, `load` at edge N:**
  - From edge N+2, `tx` is 0,1,0,1,0,1,0,1,0,1, each held 4 cycles.
  - `tx_rdy` rises at edge N+42.
- **8-bit even parity (`eight`=1, `pen`=1, `ohel`=0), 0x03:**
  - bit nine = 0, bit ten = 0.
  - Same settings with `ohel`=1: bit ten = 1.
- **7-bit odd parity (`eight`=0, `pen`=1, `ohel`=1), 0x01:**
  - data 1,0,0,0,0,0,0, then bit nine = 0, bit ten = 1.
- **`load`=1 with 0xFF at the 5th bit of a 0x00 frame:**
  - Frame unchanged.
  - No second frame.
  - `tx_rdy` timing unchanged.
- **Back-to-back:** `load` 0xA5 in the first `tx_rdy` cycle after a frame.
  - Start bit after exactly 2 idle cycles.
  - Frame correct.
- **Reset mid-frame:** `rst_n`=0 during bit 4 (data).
  - `tx`=1 and `tx_rdy`=1 before the next edge.
  - After release, a fresh `load` of 0x3C sends a correct frame.
- **`baud_k`=0:** behaves as k=2 (each bit 2 cycles).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
package uart_pkg;

    localparam int FRAME_BITS     = 10;
    localparam int BAUD_MIN       = 2;
    localparam int BAUD_W_DEFAULT = 20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SEND    = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_tx_engine_bit_9_10_decoder.sv
// Resolves the two trailing frame bits from data width and parity mode.
module bit_9_10_decoder
    import uart_pkg::*;
(
    input  logic [7:0] ldata,
    input  logic       eight,
    input  logic       pen,
    input  logic       ohel,
    output logic       bit_nine,
    output logic       bit_ten
);

    logic par7;
    logic par8;

    // Odd parity is the complement of the XOR reduction.
    assign par7 = (^ldata[6:0]) ^ ohel;
    assign par8 = (^ldata) ^ ohel;

    always_comb begin
        bit_nine = 1'b1;
        bit_ten  = 1'b1;
        case ({eight, pen})
            2'b10: begin
                bit_nine = ldata[7];
            end
            2'b11: begin
                bit_nine = ldata[7];
                bit_ten  = par8;
            end
            2'b01: begin
                bit_nine = par7;
            end
            default: begin
                bit_nine = 1'b1;
                bit_ten  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: captures a byte, frames it and shifts it out LSB-first.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int BAUD_W = BAUD_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [7:0]        out_port,
    input  logic              eight,
    input  logic              pen,
    input  logic              ohel,
    input  logic [BAUD_W-1:0] baud_k,
    output logic              tx,
    output logic              tx_rdy
);

    tx_state_e         state_q, state_d;
    logic [7:0]        ldata_q, ldata_d;
    logic [9:0]        sr_q, sr_d;
    logic [BAUD_W-1:0] k_q, k_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [3:0]        bit_q, bit_d;
    logic              doit_q, doit_d;
    logic              tx_rdy_q, tx_rdy_d;

    logic              bit_nine;
    logic              bit_ten;
    logic              btu;
    logic [BAUD_W-1:0] k_clamped;

    bit_9_10_decoder u_dec (
        .ldata    (ldata_q),
        .eight    (eight),
        .pen      (pen),
        .ohel     (ohel),
        .bit_nine (bit_nine),
        .bit_ten  (bit_ten)
    );

    assign k_clamped = (baud_k < BAUD_W'(BAUD_MIN)) ? BAUD_W'(BAUD_MIN) : baud_k;

    assign btu = doit_q && (state_q == SEND) && (baud_q == k_q - 1'b1);

    always_comb begin
        state_d  = state_q;
        ldata_d  = ldata_q;
        sr_d     = sr_q;
        k_d      = k_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        doit_d   = doit_q;
        tx_rdy_d = tx_rdy_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    ldata_d  = out_port;
                    tx_rdy_d = 1'b0;
                    state_d  = CAPTURE;
                end
            end
            CAPTURE: begin
                sr_d    = {bit_ten, bit_nine, ldata_q[6:0], 1'b0};
                k_d     = k_clamped;
                baud_d  = '0;
                bit_d   = '0;
                doit_d  = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (btu) begin
                    baud_d = '0;
                    // Last bit time done: release the line and go idle.
                    if (bit_q == 4'(FRAME_BITS - 1)) begin
                        bit_d    = '0;
                        sr_d     = '1;
                        doit_d   = 1'b0;
                        tx_rdy_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sr_d  = {1'b1, sr_q[9:1]};
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ldata_q  <= '0;
            sr_q     <= '1;
            k_q      <= BAUD_W'(BAUD_MIN);
            baud_q   <= '0;
            bit_q    <= '0;
            doit_q   <= 1'b0;
            tx_rdy_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            ldata_q  <= ldata_d;
            sr_q     <= sr_d;
            k_q      <= k_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            doit_q   <= doit_d;
            tx_rdy_q <= tx_rdy_d;
        end
    end

    assign tx     = sr_q[0];
    assign tx_rdy = tx_rdy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: directed table plus random frames.
module tb_uart_tx_engine;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [7:0]  out_port;
    logic        eight;
    logic        pen;
    logic        ohel;
    logic [19:0] baud_k;
    logic        tx;
    logic        tx_rdy;

    int checks   = 0;
    int failures = 0;

    uart_tx_engine #(.BAUD_W(20)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .out_port (out_port),
        .eight    (eight),
        .pen      (pen),
        .ohel     (ohel),
        .baud_k   (baud_k),
        .tx       (tx),
        .tx_rdy   (tx_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       e;
        logic       p;
        logic       o;
        int         k;
        bit         midload;
        logic [9:0] exp;
    } vec_t;

    task automatic chk(input string nm, input int idx,
                       input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] {tx,tx_rdy} got=%b want=%b t=%0t",
                     nm, idx, act, exp, $time);
        end
    endtask

    // Reference frame: slot 0 is the start bit, slot 9 is bit ten.
    function automatic logic [9:0] model_frame(input logic [7:0] d,
                                               input logic e, input logic p,
                                               input logic o);
        int ones7;
        int ones8;
        logic nine;
        logic ten;
        logic [9:0] f;
        ones7 = 0;
        for (int i = 0; i < 7; i++) ones7 += int'(d[i]);
        ones8 = ones7 + int'(d[7]);
        if (e) nine = d[7];
        else if (p) nine = ((ones7 % 2) == 1) ^ o;
        else nine = 1'b1;
        if (e && p) ten = ((ones8 % 2) == 1) ^ o;
        else ten = 1'b1;
        f[0] = 1'b0;
        for (int i = 0; i < 7; i++) f[i+1] = d[i];
        f[8] = nine;
        f[9] = ten;
        return f;
    endfunction

    // Starts at a negedge with the engine idle; ends at the negedge of the
    // first tx_rdy=1 cycle so a following call is a back-to-back load.
    task automatic send_check(input logic [7:0] d, input logic e,
                              input logic p, input logic o, input int kin,
                              input logic [9:0] exp, input string nm,
                              input bit midload);
        int ke;
        ke = (kin < 2) ? 2 : kin;
        load     = 1'b1;
        out_port = d;
        eight    = e;
        pen      = p;
        ohel     = o;
        baud_k   = 20'(kin);
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        chk({nm, "_cap"}, 0, {tx, tx_rdy}, 2'b10);
        @(posedge clk);
        for (int c = 0; c < 10 * ke; c++) begin
            @(negedge clk);
            chk(nm, c, {tx, tx_rdy}, {exp[c / ke], 1'b0});
            if (c == 0) begin
                out_port = 8'($urandom);
                eight    = 1'($urandom);
                pen      = 1'($urandom);
                ohel     = 1'($urandom);
                baud_k   = 20'($urandom_range(0, 9));
            end
            if (midload) begin
                load     = (c == 4 * ke);
                out_port = 8'hFF;
            end
            @(posedge clk);
        end
        load = 1'b0;
        @(negedge clk);
        chk({nm, "_done"}, 0, {tx, tx_rdy}, 2'b11);
    endtask

    task automatic idle_check(input string nm, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(nm, i, {tx, tx_rdy}, 2'b11);
        end
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 4, 1'b0, 10'h2AA};
        vecs[1] = '{8'h03, 1'b1, 1'b1, 1'b0, 3, 1'b0, 10'h006};
        vecs[2] = '{8'h03, 1'b1, 1'b1, 1'b1, 3, 1'b0, 10'h206};
        vecs[3] = '{8'h01, 1'b0, 1'b1, 1'b1, 2, 1'b0, 10'h202};
        vecs[4] = '{8'h80, 1'b0, 1'b0, 1'b0, 2, 1'b0, 10'h300};
        vecs[5] = '{8'h55, 1'b1, 1'b0, 1'b0, 0, 1'b0, 10'h2AA};
        vecs[6] = '{8'h00, 1'b1, 1'b0, 1'b0, 3, 1'b1, 10'h200};

        rst_n    = 1'b0;
        load     = 1'b1;
        out_port = 8'hA5;
        eight    = 1'b1;
        pen      = 1'b0;
        ohel     = 1'b0;
        baud_k   = 20'd4;
        #12;
        chk("reset", 0, {tx, tx_rdy}, 2'b11);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_load", 0, {tx, tx_rdy}, 2'b11);
        @(negedge clk);
        load  = 1'b0;
        rst_n = 1'b1;
        idle_check("post_reset", 2);

        for (int i = 0; i < 7; i++) begin
            send_check(vecs[i].d, vecs[i].e, vecs[i].p, vecs[i].o,
                       vecs[i].k, vecs[i].exp, $sformatf("vec%0d", i),
                       vecs[i].midload);
            idle_check($sformatf("vec%0d_idle", i), 3);
        end

        send_check(8'h55, 1'b1, 1'b0, 1'b0, 2, 10'h2AA, "b2b_a", 1'b0);
        send_check(8'hA5, 1'b1, 1'b0, 1'b0, 2, 10'h34A, "b2b_b", 1'b0);
        idle_check("b2b_idle", 2);

        load     = 1'b1;
        out_port = 8'h00;
        eight    = 1'b1;
        pen      = 1'b0;
        ohel     = 1'b0;
        baud_k   = 20'd3;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        @(posedge clk);
        repeat (13) @(posedge clk);
        #1;
        chk("pre_abort", 0, {tx, tx_rdy}, 2'b00);
        rst_n = 1'b0;
        #1;
        chk("abort", 0, {tx, tx_rdy}, 2'b11);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check("abort_idle", 2);
        send_check(8'h3C, 1'b1, 1'b0, 1'b0, 3, 10'h278, "after_abort", 1'b0);

        for (int i = 0; i < 20; i++) begin
            logic [7:0] d;
            logic e, p, o;
            int k;
            d = 8'($urandom);
            e = 1'($urandom);
            p = 1'($urandom);
            o = 1'($urandom);
            k = $urandom_range(0, 5);
            send_check(d, e, p, o, k, model_frame(d, e, p, o),
                       $sformatf("rnd%0d", i), 1'($urandom));
            if ($urandom_range(0, 1) == 1)
                idle_check($sformatf("rnd%0d_idle", i), $urandom_range(1, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
